// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit 7-segment driver with tear-free double-buffered loading
module seg7_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int CLK_DIV        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  lz_supp,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic [6:0] HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  wrap, last, boundary;
  logic [4*N_DIGITS-1:0] pval, dval;
  logic [N_DIGITS-1:0]   pdp, pblank, ddp, dblank;
  logic                  pv;
  logic [N_DIGITS-1:0]   hz;
  logic                  z;
  logic [3:0]            nib;
  logic                  dark;
  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [N_DIGITS-1:0]   an_r;
  assign wrap     = en && cnt == CW'(CLK_DIV - 1);
  assign last     = idx == IW'(N_DIGITS - 1);
  assign boundary = wrap && last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= last ? '0 : idx + 1'b1;
    end
  end
  // A load on the boundary cycle bypasses the pending stage so it is never lost or delayed a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pval   <= '0;
      pdp    <= '0;
      pblank <= '0;
      pv     <= 1'b0;
      dval   <= '0;
      ddp    <= '0;
      dblank <= '0;
    end else if (boundary) begin
      pv <= 1'b0;
      if (load) {dval, ddp, dblank} <= {value, dp_in, blank};
      else if (pv) {dval, ddp, dblank} <= {pval, pdp, pblank};
    end else if (load) begin
      {pval, pdp, pblank} <= {value, dp_in, blank};
      pv <= 1'b1;
    end
  end
  // hz[k]: digit k and every digit above it are zero.
  always_comb begin
    hz = '0;
    z  = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      z     = z && dval[4*k +: 4] == 4'd0;
      hz[k] = z;
    end
  end
  assign nib  = dval[4*idx +: 4];
  assign dark = dblank[idx] || (lz_supp && idx != '0 && hz[idx]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r      <= '0;
      dp_r       <= 1'b0;
      an_r       <= '0;
      frame_tick <= 1'b0;
    end else begin
      seg_r      <= en && !dark ? HEX[nib] : '0;
      dp_r       <= en && ddp[idx] && !dblank[idx];
      an_r       <= en ? N_DIGITS'(1) << idx : '0;
      frame_tick <= boundary;
    end
  end
  assign seg = seg_r ^ {7{SEG_ACTIVE_LOW}};
  assign dp  = dp_r ^ SEG_ACTIVE_LOW;
  assign an  = an_r ^ {N_DIGITS{AN_ACTIVE_LOW}};
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench; active-high and active-low instances share one reference model
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int C = 4;
  localparam int P = N * C;
  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;
    logic         ft;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0, lz_supp = 1'b0;
  logic [4*N-1:0] value = '0;
  logic [N-1:0] dp_in = '0, blank = '0;
  logic [6:0] seg0, seg1;
  logic dp0, dp1, ft0, ft1;
  logic [N-1:0] an0, an1;
  int vectors = 0, errors = 0;
  exp_t q[$];
  logic [6:0] tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  int pos;
  logic [4*N-1:0] dv, pvv;
  logic [N-1:0] ddp, dbl, pdp, pbl;
  bit pv;

  seg7_scan_driver #(.N_DIGITS(N), .CLK_DIV(C), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .blank(blank), .lz_supp(lz_supp), .seg(seg0), .dp(dp0), .an(an0), .frame_tick(ft0));
  seg7_scan_driver #(.N_DIGITS(N), .CLK_DIV(C), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .blank(blank), .lz_supp(lz_supp), .seg(seg1), .dp(dp1), .an(an1), .frame_tick(ft1));

  always #5 clk = ~clk;

  // Reference model: scan position as a plain frame-cycle number, digits read by shifting.
  always @(posedge clk) begin
    exp_t e;
    int i;
    bit bd;
    e = '0;
    if (!rst_n) begin
      pos = 0; dv = '0; ddp = '0; dbl = '0; pvv = '0; pdp = '0; pbl = '0; pv = 0;
    end else begin
      i = pos / C;
      if (en) begin
        e.an  = N'(1 << i);
        e.dp  = ddp[i] && !dbl[i];
        e.seg = (dbl[i] || (lz_supp && i != 0 && (dv >> (4*i)) == 0)) ? 7'd0 : tbl[dv[4*i +: 4]];
        e.ft  = pos == P - 1;
      end
      bd = en && pos == P - 1;
      if (en) pos = (pos + 1) % P;
      if (load && bd) begin
        dv = value; ddp = dp_in; dbl = blank; pv = 0;
      end else begin
        if (bd && pv) begin
          dv = pvv; ddp = pdp; dbl = pbl; pv = 0;
        end
        if (load) begin
          pvv = value; pdp = dp_in; pbl = blank; pv = 1;
        end
      end
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    vectors++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL underflow t=%0t no expected entry queued", $time);
    end else begin
      e = q.pop_front();
      if (!rst_n) e = '0;
      if ({seg0, dp0, an0, ft0} !== e ||
          {seg1, dp1, an1, ft1} !== {~e.seg, ~e.dp, ~e.an, e.ft}) begin
        errors++;
        $display("FAIL outputs t=%0t hi seg=%b dp=%b an=%b ft=%b lo seg=%b dp=%b an=%b ft=%b exp seg=%b dp=%b an=%b ft=%b",
                 $time, seg0, dp0, an0, ft0, seg1, dp1, an1, ft1, e.seg, e.dp, e.an, e.ft);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] d, input logic [N-1:0] b);
    load = 1'b1; value = v; dp_in = d; blank = b;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    en = 1'b1;
    do_load(16'h1234, '0, '0);
    cyc(40);
    cyc(5);
    do_load(16'hABCD, '0, '0);
    cyc(1);
    do_load(16'h0008, '0, '0);
    cyc(40);
    lz_supp = 1'b1;
    do_load(16'h0050, '0, '0);
    cyc(36);
    do_load(16'h0000, '0, '0);
    cyc(36);
    lz_supp = 1'b0;
    do_load(16'h8888, 4'b0011, 4'b0010);
    cyc(36);
    cyc(2);
    en = 1'b0;
    cyc(4);
    do_load(16'h1357, 4'b0100, '0);
    cyc(6);
    en = 1'b1;
    cyc(40);
    for (int n = 0; n < 900; n++) begin
      en = $urandom_range(0, 9) != 0;
      load = $urandom_range(0, 4) == 0;
      for (int k = 0; k < N; k++) value[4*k +: 4] = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
      dp_in = N'($urandom);
      blank = $urandom_range(0, 3) == 0 ? N'($urandom) : '0;
      if ($urandom_range(0, 19) == 0) lz_supp = ~lz_supp;
      cyc(1);
    end
    load = 1'b0;
    en = 1'b1;
    lz_supp = 1'b1;
    do_load(16'h4321, 4'b1111, '0);
    cyc(23);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
